hash_lookup_sequencer: RTL and testbench



---
 rtl/hash_seq_pkg.sv | 25 ++
 rtl/hash_dup_detect.sv | 26 ++
 rtl/hash_lookup_sequencer.sv | 123 ++++++++++++
 tb/tb_hash_lookup_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_seq_pkg.sv
// Shared definitions for the hash lookup sequencer.
// Holds the datapath widths, the sequencer state type and the packed
// bucket-index array type used by the top level and the duplicate detector.
package hash_seq_pkg;

  localparam int VPN_W     = 45;
  localparam int HASH_W    = 32;
  localparam int NUM_HASH  = 8;
  localparam int IDX_W     = 10;
  localparam int HASH_ID_W = 3;

  // Last hash id issued for a request.
  localparam logic [HASH_ID_W-1:0] LAST_ID = HASH_ID_W'(NUM_HASH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } state_t;

  // Element k occupies bits [k*IDX_W +: IDX_W] when flattened.
  typedef logic [NUM_HASH-1:0][IDX_W-1:0] idx_arr_t;

endpackage

// File: rtl/hash_dup_detect.sv
// Duplicate bucket-index detector.
// Purely combinational pairwise compare triangle: bit k of the mask is set
// when index k equals any lower-numbered index j<k. Bit 0 is therefore 0.
// Ports:
//   idx_i  packed NUM_HASH x IDX_W bucket indices
//   dup_o  NUM_HASH duplicate mask
module hash_dup_detect
  import hash_seq_pkg::*;
(
  input  logic [NUM_HASH*IDX_W-1:0] idx_i,
  output logic [NUM_HASH-1:0]       dup_o
);

  idx_arr_t idx;
  assign idx = idx_i;

  always_comb begin
    dup_o = '0;
    for (int k = 1; k < NUM_HASH; k++) begin
      for (int j = 0; j < k; j++) begin
        if (idx[k] == idx[j]) dup_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash_lookup_sequencer.sv
// Initiator side of the tabulation hash unit.
// Accepts one VPN lookup, drives the hash unit with that VPN and ids
// 0..NUM_HASH-1 on consecutive cycles, captures the registered results
// (truncated to bucket indices), flags duplicate indices and returns one
// response bundle through a valid/ready handshake.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     request handshake, req_vpn sampled on accept
//   hash_vpn, hash_id       operands presented to the hash unit
//   hash_result             hash unit output, one cycle behind its operands
//   resp_valid/resp_ready   response handshake
//   resp_vpn, resp_idx      accepted VPN and packed bucket indices
//   resp_dup                duplicate mask over resp_idx
module hash_lookup_sequencer
  import hash_seq_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [VPN_W-1:0]          req_vpn,
  output logic [VPN_W-1:0]          hash_vpn,
  output logic [HASH_ID_W-1:0]      hash_id,
  input  logic [HASH_W-1:0]         hash_result,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [VPN_W-1:0]          resp_vpn,
  output logic [NUM_HASH*IDX_W-1:0] resp_idx,
  output logic [NUM_HASH-1:0]       resp_dup
);

  state_t                  state_q;
  logic                    req_ready_q;
  logic                    resp_valid_q;
  logic [VPN_W-1:0]        hash_vpn_q;
  logic [VPN_W-1:0]        resp_vpn_q;
  logic [HASH_ID_W-1:0]    hash_id_q;
  logic [HASH_ID_W-1:0]    cap_idx_q;
  logic                    cap_vld_q;
  idx_arr_t                idx_q;
  idx_arr_t                idx_d;
  logic [NUM_HASH-1:0]     dup_q;
  logic [NUM_HASH-1:0]     dup_d;

  // Upper hash bits are discarded by truncation.
  logic unused_hash_hi;
  assign unused_hash_hi = ^hash_result[HASH_W-1:IDX_W];

  // Index array including the result being captured this cycle, so the
  // duplicate mask registered on entry to RESP already sees the last slice.
  always_comb begin
    idx_d = idx_q;
    if (cap_vld_q) idx_d[cap_idx_q] = hash_result[IDX_W-1:0];
  end

  hash_dup_detect u_dup (
    .idx_i (idx_d),
    .dup_o (dup_d)
  );

  // Sequencer FSM. The capture index/valid pair trails the issued id by one
  // cycle to line up with the hash unit's registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      hash_vpn_q   <= '0;
      resp_vpn_q   <= '0;
      hash_id_q    <= '0;
      cap_idx_q    <= '0;
      cap_vld_q    <= 1'b0;
      idx_q        <= '0;
      dup_q        <= '0;
    end else begin
      cap_vld_q <= (state_q == ISSUE);
      cap_idx_q <= hash_id_q;
      idx_q     <= idx_d;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            hash_vpn_q  <= req_vpn;
            resp_vpn_q  <= req_vpn;
            hash_id_q   <= '0;
            req_ready_q <= 1'b0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (hash_id_q == LAST_ID) begin
            hash_id_q <= '0;
            state_q   <= DRAIN;
          end else begin
            hash_id_q <= hash_id_q + 1'b1;
          end
        end
        DRAIN: begin
          dup_q        <= dup_d;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign hash_vpn   = hash_vpn_q;
  assign hash_id    = hash_id_q;
  assign resp_vpn   = resp_vpn_q;
  assign resp_idx   = idx_q;
  assign resp_dup   = dup_q;

endmodule

// File: tb/tb_hash_lookup_sequencer.sv
// Self-checking bench for hash_lookup_sequencer. A behavioural hash unit
// model answers the DUT one cycle late; expected indices, duplicate masks
// and timing come from the hash functions and plain loops.
module tb_hash_lookup_sequencer;
  import hash_seq_pkg::*;

  logic                      clk;
  logic                      rst_n;
  logic                      req_valid;
  logic                      req_ready;
  logic [VPN_W-1:0]          req_vpn;
  logic [VPN_W-1:0]          hash_vpn;
  logic [HASH_ID_W-1:0]      hash_id;
  logic [HASH_W-1:0]         hash_result;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [VPN_W-1:0]          resp_vpn;
  logic [NUM_HASH*IDX_W-1:0] resp_idx;
  logic [NUM_HASH-1:0]       resp_dup;

  int total;
  int bad;
  int mode;
  int lat;
  logic [HASH_ID_W-1:0] seen_id   [0:NUM_HASH];
  logic [VPN_W-1:0]     seen_hvpn [0:NUM_HASH];

  hash_lookup_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_vpn     (req_vpn),
    .hash_vpn    (hash_vpn),
    .hash_id     (hash_id),
    .hash_result (hash_result),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_vpn    (resp_vpn),
    .resp_idx    (resp_idx),
    .resp_dup    (resp_dup)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hash functions selectable per test
  function automatic logic [31:0] hmodel(int m, logic [VPN_W-1:0] v, logic [2:0] k);
    case (m)
      0:       return {29'd0, k} * 32'h100 + {24'd0, v[7:0]};
      1:       return {22'd0, k, v[6:0]};
      2:       return (v[31:0] ^ {19'd0, v[44:32]}) * 32'h9E3779B1 + {29'd0, k} * 32'h85EBCA6B;
      default: return {29'd0, v[2:0] ^ k} & 32'h6;
    endcase
  endfunction

  // Registered hash unit model
  always @(posedge clk) hash_result <= hmodel(mode, hash_vpn, hash_id);

  function automatic logic [NUM_HASH*IDX_W-1:0] exp_idx(int m, logic [VPN_W-1:0] v);
    logic [NUM_HASH*IDX_W-1:0] r;
    logic [31:0] t;
    r = '0;
    for (int k = 0; k < NUM_HASH; k++) begin
      t = hmodel(m, v, 3'(k));
      r[k*IDX_W +: IDX_W] = t[IDX_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [NUM_HASH-1:0] exp_dup(int m, logic [VPN_W-1:0] v);
    logic [NUM_HASH*IDX_W-1:0] r;
    logic [NUM_HASH-1:0] d;
    r = exp_idx(m, v);
    d = '0;
    for (int k = 0; k < NUM_HASH; k++)
      for (int j = 0; j < k; j++)
        if (r[k*IDX_W +: IDX_W] == r[j*IDX_W +: IDX_W]) d[k] = 1'b1;
    return d;
  endfunction

  function automatic logic [VPN_W-1:0] rand_vpn();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[VPN_W-1:0];
  endfunction

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it until resp_valid (bounded); records the
  // hash operands seen each cycle and the edge count from accept to response
  task automatic do_lookup(input logic [VPN_W-1:0] vpn, input bit scramble);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      tick();
      guard++;
    end
    req_vpn   = vpn;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      if (c <= NUM_HASH) begin
        seen_id[c]   = hash_id;
        seen_hvpn[c] = hash_vpn;
      end
      if (scramble) req_vpn = rand_vpn();
      if (resp_valid) break;
      tick();
      lat++;
    end
  endtask

  // Complete the response handshake
  task automatic finish_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  // Reset values while held and the first IDLE cycle afterwards
  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_vpn = '0; resp_ready = 1'b0; mode = 0;
    #12;
    total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_req_ready got=%b want=0", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_resp_valid got=%b want=0", resp_valid); end
    total++; if (hash_vpn !== '0) begin bad++; $display("[TB] FAIL rst_hash_vpn got=%h want=0", hash_vpn); end
    total++; if (hash_id !== '0) begin bad++; $display("[TB] FAIL rst_hash_id got=%h want=0", hash_id); end
    total++; if (resp_vpn !== '0) begin bad++; $display("[TB] FAIL rst_resp_vpn got=%h want=0", resp_vpn); end
    total++; if (resp_idx !== '0) begin bad++; $display("[TB] FAIL rst_resp_idx got=%h want=0", resp_idx); end
    total++; if (resp_dup !== '0) begin bad++; $display("[TB] FAIL rst_resp_dup got=%h want=0", resp_dup); end
    rst_n = 1'b1;
    tick();
    total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL idle_req_ready got=%b want=1", req_ready); end
  endtask

  // Single lookup with hard expected values for 45'h1234
  task automatic test_single();
    logic [NUM_HASH*IDX_W-1:0] want;
    want = {10'h334, 10'h234, 10'h134, 10'h034, 10'h334, 10'h234, 10'h134, 10'h034};
    mode = 0;
    do_lookup(45'h1234, 1'b0);
    total++; if (lat !== NUM_HASH + 1) begin bad++; $display("[TB] FAIL single_latency got=%0d want=%0d", lat, NUM_HASH + 1); end
    total++; if (resp_idx !== want) begin bad++; $display("[TB] FAIL single_idx got=%h want=%h", resp_idx, want); end
    total++; if (resp_dup !== 8'b1111_0000) begin bad++; $display("[TB] FAIL single_dup got=%b want=11110000", resp_dup); end
    total++; if (resp_vpn !== 45'h1234) begin bad++; $display("[TB] FAIL single_vpn got=%h want=1234", resp_vpn); end
    finish_resp();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_drop_valid got=%b want=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_ready_back got=%b want=1", req_ready); end
  endtask

  // Distinct indices and the hash operand sequence
  task automatic test_distinct();
    mode = 1;
    do_lookup(45'h7F, 1'b0);
    for (int k = 0; k < NUM_HASH; k++) begin
      total++; if (seen_id[k] !== 3'(k)) begin bad++; $display("[TB] FAIL distinct_id%0d got=%0d want=%0d", k, seen_id[k], k); end
      total++; if (seen_hvpn[k] !== 45'h7F) begin bad++; $display("[TB] FAIL distinct_hvpn%0d got=%h want=7f", k, seen_hvpn[k]); end
    end
    total++; if (seen_id[NUM_HASH] !== '0) begin bad++; $display("[TB] FAIL distinct_id_drain got=%0d want=0", seen_id[NUM_HASH]); end
    total++; if (resp_dup !== 8'h00) begin bad++; $display("[TB] FAIL distinct_dup got=%h want=00", resp_dup); end
    total++; if (resp_idx !== exp_idx(1, 45'h7F)) begin bad++; $display("[TB] FAIL distinct_idx got=%h want=%h", resp_idx, exp_idx(1, 45'h7F)); end
    finish_resp();
  endtask

  // Response held under back-pressure, new requests refused
  task automatic test_backpressure();
    logic [VPN_W-1:0] v;
    v = rand_vpn();
    mode = 3;
    do_lookup(v, 1'b0);
    total++; if (lat !== NUM_HASH + 1) begin bad++; $display("[TB] FAIL bp_latency got=%0d want=%0d", lat, NUM_HASH + 1); end
    req_vpn = rand_vpn();
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      total++; if (resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid c%0d got=%b want=1", i, resp_valid); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_req_ready c%0d got=%b want=0", i, req_ready); end
      total++; if (resp_vpn !== v) begin bad++; $display("[TB] FAIL bp_vpn c%0d got=%h want=%h", i, resp_vpn, v); end
      total++; if (resp_idx !== exp_idx(3, v)) begin bad++; $display("[TB] FAIL bp_idx c%0d got=%h want=%h", i, resp_idx, exp_idx(3, v)); end
      total++; if (resp_dup !== exp_dup(3, v)) begin bad++; $display("[TB] FAIL bp_dup c%0d got=%b want=%b", i, resp_dup, exp_dup(3, v)); end
      tick();
    end
    req_valid = 1'b0;
    finish_resp();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_valid got=%b want=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready got=%b want=1", req_ready); end
  endtask

  // Two requests with req_valid held high and resp_ready high
  task automatic test_back_to_back();
    int acc_edge [2];
    int n_acc;
    bit acc;
    logic [VPN_W-1:0] q_vpn [$];
    logic [NUM_HASH*IDX_W-1:0] q_idx [$];
    mode = 2;
    n_acc = 0;
    acc_edge[0] = 0;
    acc_edge[1] = 0;
    req_vpn = 45'h1; req_valid = 1'b1; resp_ready = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      acc = req_valid && req_ready;
      tick();
      if (acc) begin
        if (n_acc < 2) acc_edge[n_acc] = e;
        n_acc++;
        if (n_acc == 1) req_vpn = 45'h2;
        else req_valid = 1'b0;
      end
      if (resp_valid) begin
        q_vpn.push_back(resp_vpn);
        q_idx.push_back(resp_idx);
      end
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    total++; if (n_acc !== 2) begin bad++; $display("[TB] FAIL b2b_accepts got=%0d want=2", n_acc); end
    total++; if (acc_edge[1] - acc_edge[0] !== NUM_HASH + 3) begin bad++; $display("[TB] FAIL b2b_interval got=%0d want=%0d", acc_edge[1] - acc_edge[0], NUM_HASH + 3); end
    total++; if (q_vpn.size() !== 2) begin bad++; $display("[TB] FAIL b2b_resp_count got=%0d want=2", q_vpn.size()); end
    if (q_vpn.size() >= 2) begin
      total++; if (q_vpn[0] !== 45'h1) begin bad++; $display("[TB] FAIL b2b_vpn0 got=%h want=1", q_vpn[0]); end
      total++; if (q_vpn[1] !== 45'h2) begin bad++; $display("[TB] FAIL b2b_vpn1 got=%h want=2", q_vpn[1]); end
      total++; if (q_idx[0] !== exp_idx(2, 45'h1)) begin bad++; $display("[TB] FAIL b2b_idx0 got=%h want=%h", q_idx[0], exp_idx(2, 45'h1)); end
      total++; if (q_idx[1] !== exp_idx(2, 45'h2)) begin bad++; $display("[TB] FAIL b2b_idx1 got=%h want=%h", q_idx[1], exp_idx(2, 45'h2)); end
    end
  endtask

  // Reset asserted in the middle of issuing
  task automatic test_reset_mid_issue();
    int guard;
    int pulses;
    mode = 0;
    req_vpn = rand_vpn();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    guard = 0;
    while (hash_id !== 3'd3 && guard < 20) begin
      tick();
      guard++;
    end
    total++; if (hash_id !== 3'd3) begin bad++; $display("[TB] FAIL mid_reach_id3 got=%0d want=3", hash_id); end
    rst_n = 1'b0;
    #1;
    total++; if (hash_id !== '0) begin bad++; $display("[TB] FAIL mid_hash_id got=%0d want=0", hash_id); end
    total++; if (hash_vpn !== '0) begin bad++; $display("[TB] FAIL mid_hash_vpn got=%h want=0", hash_vpn); end
    total++; if (resp_vpn !== '0) begin bad++; $display("[TB] FAIL mid_resp_vpn got=%h want=0", resp_vpn); end
    total++; if (resp_idx !== '0) begin bad++; $display("[TB] FAIL mid_resp_idx got=%h want=0", resp_idx); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_req_ready got=%b want=0", req_ready); end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (resp_valid) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (resp_valid) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL mid_no_resp got=%0d want=0", pulses); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_ready_after got=%b want=1", req_ready); end
    do_lookup(45'h55, 1'b0);
    total++; if (seen_id[0] !== '0 || seen_id[NUM_HASH-1] !== LAST_ID) begin bad++; $display("[TB] FAIL mid_ids got=%0d..%0d want=0..7", seen_id[0], seen_id[NUM_HASH-1]); end
    total++; if (lat !== NUM_HASH + 1) begin bad++; $display("[TB] FAIL mid_latency got=%0d want=%0d", lat, NUM_HASH + 1); end
    total++; if (resp_vpn !== 45'h55) begin bad++; $display("[TB] FAIL mid_vpn got=%h want=55", resp_vpn); end
    total++; if (resp_idx !== exp_idx(0, 45'h55)) begin bad++; $display("[TB] FAIL mid_idx got=%h want=%h", resp_idx, exp_idx(0, 45'h55)); end
    total++; if (resp_dup !== exp_dup(0, 45'h55)) begin bad++; $display("[TB] FAIL mid_dup got=%b want=%b", resp_dup, exp_dup(0, 45'h55)); end
    finish_resp();
  endtask

  // req_vpn changes every cycle after acceptance
  task automatic test_isolation();
    logic [VPN_W-1:0] v;
    v = rand_vpn();
    mode = 0;
    do_lookup(v, 1'b1);
    for (int k = 0; k < NUM_HASH; k++) begin
      total++; if (seen_hvpn[k] !== v) begin bad++; $display("[TB] FAIL iso_hvpn%0d got=%h want=%h", k, seen_hvpn[k], v); end
    end
    total++; if (resp_vpn !== v) begin bad++; $display("[TB] FAIL iso_vpn got=%h want=%h", resp_vpn, v); end
    total++; if (resp_idx !== exp_idx(0, v)) begin bad++; $display("[TB] FAIL iso_idx got=%h want=%h", resp_idx, exp_idx(0, v)); end
    finish_resp();
  endtask

  // Randomised lookups with random hash flavour and response delay
  task automatic test_random();
    logic [VPN_W-1:0] v;
    int hold;
    for (int n = 0; n < 8; n++) begin
      v = rand_vpn();
      mode = 2 + int'($urandom_range(0, 1));
      do_lookup(v, 1'($urandom_range(0, 1)));
      total++; if (lat !== NUM_HASH + 1) begin bad++; $display("[TB] FAIL rnd%0d_latency got=%0d want=%0d", n, lat, NUM_HASH + 1); end
      hold = int'($urandom_range(0, 3));
      for (int i = 0; i < hold; i++) tick();
      total++; if (resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL rnd%0d_valid got=%b want=1", n, resp_valid); end
      total++; if (resp_vpn !== v) begin bad++; $display("[TB] FAIL rnd%0d_vpn got=%h want=%h", n, resp_vpn, v); end
      total++; if (resp_idx !== exp_idx(mode, v)) begin bad++; $display("[TB] FAIL rnd%0d_idx got=%h want=%h", n, resp_idx, exp_idx(mode, v)); end
      total++; if (resp_dup !== exp_dup(mode, v)) begin bad++; $display("[TB] FAIL rnd%0d_dup got=%b want=%b", n, resp_dup, exp_dup(mode, v)); end
      finish_resp();
      total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rnd%0d_drop got=%b want=0", n, resp_valid); end
    end
  endtask

  // Test sequence
  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single();
    test_distinct();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_issue();
    test_isolation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
